// File: rtl/lut_cfg_loader.sv
// Serial configuration transmitter for a chain of K-input LUTs.
// Accepts a truth-table word over valid/ready and shifts it out on en/S.
module lut_cfg_loader #(
  parameter int K         = 3,
  parameter int NUM_LUTS  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LUTS*(2**K)-1:0]      cfg_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  output logic                            en,
  output logic                            S,
  output logic                            busy,
  output logic                            done
);

  localparam int CFG_W = 2**K;
  localparam int TOTAL = NUM_LUTS * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state;
  logic [TOTAL-1:0]   sreg;
  logic [CNT_W-1:0]   cnt;

  function automatic logic head_bit(input logic [TOTAL-1:0] v);
    return (MSB_FIRST != 0) ? v[TOTAL-1] : v[0];
  endfunction

  function automatic logic [TOTAL-1:0] advance(input logic [TOTAL-1:0] v);
    return (MSB_FIRST != 0) ? {v[TOTAL-2:0], 1'b0} : {1'b0, v[TOTAL-1:1]};
  endfunction

  // The head bit is registered into S on the same edge the word is latched,
  // so sreg always holds the bits still to be presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      S         <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (cfg_valid && cfg_ready) begin
            sreg      <= advance(cfg_data);
            S         <= head_bit(cfg_data);
            cnt       <= '0;
            en        <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == LAST) begin
            en    <= 1'b0;
            S     <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            S    <= head_bit(sreg);
            sreg <= advance(sreg);
            cnt  <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          en        <= 1'b0;
          S         <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader: MSB-first single LUT, LSB-first single
// LUT and a two-LUT chain, each followed by a behavioural LUT shift model.
module tb_lut_cfg_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  data_a = '0;
  logic        valid_a = 1'b0;
  logic        ready_a, en_a, s_a, busy_a, done_a;
  logic [7:0]  data_b = '0;
  logic        valid_b = 1'b0;
  logic        ready_b, en_b, s_b, busy_b, done_b;
  logic [15:0] data_c = '0;
  logic        valid_c = 1'b0;
  logic        ready_c, en_c, s_c, busy_c, done_c;

  int checks = 0;
  int errors = 0;

  lut_cfg_loader #(.K(3), .NUM_LUTS(1), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_data(data_a), .cfg_valid(valid_a),
    .cfg_ready(ready_a), .en(en_a), .S(s_a), .busy(busy_a), .done(done_a));

  lut_cfg_loader #(.K(3), .NUM_LUTS(1), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_data(data_b), .cfg_valid(valid_b),
    .cfg_ready(ready_b), .en(en_b), .S(s_b), .busy(busy_b), .done(done_b));

  lut_cfg_loader #(.K(3), .NUM_LUTS(2), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .cfg_data(data_c), .cfg_valid(valid_c),
    .cfg_ready(ready_c), .en(en_c), .S(s_c), .busy(busy_c), .done(done_c));

  // Behavioural LUTs: shift S in at bit 0 while en is high, evaluate mem[{A,B,C}].
  logic [7:0]  lut_a;
  logic [7:0]  lut_b;
  logic [15:0] chain_c;
  always_ff @(posedge clk) begin
    if (en_a) lut_a <= {lut_a[6:0], s_a};
    if (en_b) lut_b <= {lut_b[6:0], s_b};
    if (en_c) chain_c <= {chain_c[14:0], s_c};
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", en_a); end
    checks++; if (s_a !== 1'b0) begin errors++; $display("FAIL reset_S got %b exp 0", s_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_a); end
    checks++; if (ready_c !== 1'b1) begin errors++; $display("FAIL reset_ready_c got %b exp 1", ready_c); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset ready %b busy %b exp 1 0", ready_a, busy_a);
    end
  endtask

  task automatic test_load_msb();
    logic [7:0] pat;
    int exp_z [8];
    pat = 8'hE8;
    exp_z = '{0, 0, 0, 1, 0, 1, 1, 1};
    @(negedge clk);
    data_a = pat; valid_a = 1'b1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL msb_ready_pre got %b exp 1", ready_a); end
    @(posedge clk); #1;
    valid_a = 1'b0; data_a = 8'h00;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++; if (en_a !== 1'(k <= 8)) begin errors++; $display("FAIL msb_en cycle %0d got %b exp %b", k, en_a, 1'(k <= 8)); end
      if (k <= 8) begin
        checks++; if (s_a !== pat[8-k]) begin errors++; $display("FAIL msb_S cycle %0d got %b exp %b", k, s_a, pat[8-k]); end
      end
      checks++; if (done_a !== 1'(k == 9)) begin errors++; $display("FAIL msb_done cycle %0d got %b exp %b", k, done_a, 1'(k == 9)); end
      checks++; if (ready_a !== 1'(k >= 10)) begin errors++; $display("FAIL msb_ready cycle %0d got %b exp %b", k, ready_a, 1'(k >= 10)); end
    end
    checks++; if (lut_a !== 8'hE8) begin errors++; $display("FAIL msb_lut got %h exp e8", lut_a); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (lut_a[i] !== 1'(exp_z[i])) begin errors++; $display("FAIL majority_z abc=%0d got %b exp %0d", i, lut_a[i], exp_z[i]); end
    end
  endtask

  task automatic test_lsb_first();
    @(negedge clk);
    data_b = 8'h01; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (en_b !== 1'(k <= 8)) begin errors++; $display("FAIL lsb_en cycle %0d got %b exp %b", k, en_b, 1'(k <= 8)); end
      checks++; if (s_b !== 1'(k == 1)) begin errors++; $display("FAIL lsb_S cycle %0d got %b exp %b", k, s_b, 1'(k == 1)); end
      checks++; if (done_b !== 1'(k == 9)) begin errors++; $display("FAIL lsb_done cycle %0d got %b exp %b", k, done_b, 1'(k == 9)); end
    end
    checks++; if (lut_b !== 8'h80) begin errors++; $display("FAIL lsb_lut got %h exp 80", lut_b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1;
    logic [7:0] p2;
    logic exp_s;
    logic exp_en;
    int low_cnt;
    p1 = 8'h96; p2 = 8'h3C; low_cnt = 0;
    @(negedge clk);
    data_a = p1; valid_a = 1'b1;
    @(posedge clk); #1;
    data_a = p2;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_en = 1'((k <= 8) || (k >= 11 && k <= 18));
      exp_s = (k <= 8) ? p1[8-k] : ((k >= 11 && k <= 18) ? p2[18-k] : 1'b0);
      checks++; if (en_a !== exp_en) begin errors++; $display("FAIL b2b_en cycle %0d got %b exp %b", k, en_a, exp_en); end
      checks++; if (s_a !== exp_s) begin errors++; $display("FAIL b2b_S cycle %0d got %b exp %b", k, s_a, exp_s); end
      checks++; if (done_a !== 1'(k == 9 || k == 19)) begin errors++; $display("FAIL b2b_done cycle %0d got %b", k, done_a); end
      if (k >= 9 && k <= 18 && en_a === 1'b0) low_cnt++;
      if (k == 11) valid_a = 1'b0;
    end
    checks++; if (low_cnt != 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", low_cnt); end
    checks++; if (lut_a !== 8'h3C) begin errors++; $display("FAIL b2b_lut got %h exp 3c", lut_a); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_a = 8'hFF; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++; if (en_a !== 1'b1 || s_a !== 1'b1) begin errors++; $display("FAIL abort_pre cycle %0d en %b S %b exp 1 1", k, en_a, s_a); end
      end else begin
        checks++; if (en_a !== 1'b0 || s_a !== 1'b0) begin errors++; $display("FAIL abort_post cycle %0d en %b S %b exp 0 0", k, en_a, s_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL abort_ready cycle %0d got %b exp 1", k, ready_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done cycle %0d got %b exp 0", k, done_a); end
      end
      if (k == 4) rst_n = 1'b0;
      if (k == 5) rst_n = 1'b1;
    end
    data_a = 8'h00; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (en_a !== 1'(k <= 8)) begin errors++; $display("FAIL reload_en cycle %0d got %b exp %b", k, en_a, 1'(k <= 8)); end
      checks++; if (s_a !== 1'b0) begin errors++; $display("FAIL reload_S cycle %0d got %b exp 0", k, s_a); end
      checks++; if (done_a !== 1'(k == 9)) begin errors++; $display("FAIL reload_done cycle %0d got %b exp %b", k, done_a, 1'(k == 9)); end
    end
    checks++; if (lut_a !== 8'h00) begin errors++; $display("FAIL reload_lut got %h exp 00", lut_a); end
  endtask

  task automatic test_reset_vs_valid();
    @(negedge clk);
    rst_n = 1'b0; data_a = 8'h5A; valid_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; valid_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (en_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
        errors++; $display("FAIL rst_wins cycle %0d en %b busy %b ready %b exp 0 0 1", k, en_a, busy_a, ready_a);
      end
    end
  endtask

  task automatic test_chain();
    logic [15:0] pat;
    int exp_z0 [8];
    pat = 16'hE896;
    exp_z0 = '{0, 1, 1, 0, 1, 0, 0, 1};
    @(negedge clk);
    data_c = pat; valid_c = 1'b1;
    @(posedge clk); #1;
    valid_c = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      checks++; if (en_c !== 1'(k <= 16)) begin errors++; $display("FAIL chain_en cycle %0d got %b exp %b", k, en_c, 1'(k <= 16)); end
      if (k <= 16) begin
        checks++; if (s_c !== pat[16-k]) begin errors++; $display("FAIL chain_S cycle %0d got %b exp %b", k, s_c, pat[16-k]); end
      end
      checks++; if (done_c !== 1'(k == 17)) begin errors++; $display("FAIL chain_done cycle %0d got %b exp %b", k, done_c, 1'(k == 17)); end
    end
    checks++; if (chain_c[7:0] !== 8'h96) begin errors++; $display("FAIL chain_lut0 got %h exp 96", chain_c[7:0]); end
    checks++; if (chain_c[15:8] !== 8'hE8) begin errors++; $display("FAIL chain_lut1 got %h exp e8", chain_c[15:8]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (chain_c[i] !== 1'(exp_z0[i])) begin errors++; $display("FAIL chain_lut0_z abc=%0d got %b exp %0d", i, chain_c[i], exp_z0[i]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_msb();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid();
    test_reset_vs_valid();
    test_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
